// File: rtl/add_issue_ctrl.sv
// add_issue_ctrl: buffers operand pairs in a small FIFO and issues them one at a
// time to an en/ack adder. It captures the sum (or a timeout error) and holds it
// on a result port.
//
// Handshake semantics (in_* and res_* ports): a transfer happens on a rising
// edge where valid && ready are both 1. Once valid is raised, the source holds
// its data stable until that edge. On the result side, res_data/res_err are held
// unchanged while res_valid=1 and res_ready=0.
module add_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_a,
  input  logic [7:0]               in_b,
  output logic                     add_en,
  output logic [7:0]               add_a,
  output logic [7:0]               add_b,
  input  logic [15:0]              add_out,
  input  logic                     add_ack,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [15:0]              res_data,
  output logic                     res_err,
  output logic [7:0]               err_cnt,
  output logic [$clog2(DEPTH):0]   fifo_cnt
);

  localparam int         AW      = $clog2(DEPTH);
  localparam int         CW      = AW + 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  // state is kept as a named enum so checkers can bind to it hierarchically
  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    to_cnt;
  logic          push;
  logic          pop;
  logic [15:0]   head;

  // in_ready depends only on occupancy; no input-to-output combinational path
  assign in_ready = (fifo_cnt != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // the head is popped when idle, or on the same edge a held result is consumed
  assign pop      = (fifo_cnt != '0) &&
                    ((state == S_IDLE) || ((state == S_RESP) && res_ready));
  assign head     = mem[rd_ptr];

  // operand storage; contents need no reset because the count gates their use
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // issue / wait / respond sequencer with registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      add_en    <= 1'b0;
      add_a     <= '0;
      add_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
      err_cnt   <= '0;
      to_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            add_a  <= head[15:8];
            add_b  <= head[7:0];
            add_en <= 1'b1;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          add_en <= 1'b0;
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          // an ack on the last allowed cycle still wins over the timeout
          if (add_ack) begin
            res_data  <= add_out;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= S_RESP;
          end else if (to_cnt == TO_LAST) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            state     <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              add_a  <= head[15:8];
              add_b  <= head[7:0];
              add_en <= 1'b1;
              state  <= S_ISSUE;
            end else begin
              state  <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_issue_ctrl.sv
// Bench for add_issue_ctrl: a behavioural adder with a programmable ack delay,
// a scoreboard of expected results and issued operands, a directed vector table
// and hand-written sequences for the multi-cycle corner cases.
module tb_add_issue_ctrl;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        add_en;
  logic [7:0]  add_a;
  logic [7:0]  add_b;
  logic [15:0] add_out;
  logic        add_ack = 1'b0;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_err;
  logic [7:0]  err_cnt;
  logic [2:0]  fifo_cnt;

  int total = 0;
  int bad   = 0;

  // scoreboard: expected results as {err, data}, expected issues as {a, b}
  logic [16:0] exp_q[$];
  logic [15:0] issue_q[$];
  int          err_model = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  add_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .add_en(add_en), .add_a(add_a), .add_b(add_b),
    .add_out(add_out), .add_ack(add_ack),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .err_cnt(err_cnt), .fifo_cnt(fifo_cnt)
  );

  // ---------------- adder model ----------------
  // ack_delay = d (>=1): ack is high in cycle N+d for an issue in cycle N; 0 = never ack
  int          ack_delay = 1;
  int          pend = 0;
  logic [15:0] sum_q = 16'd0;
  assign add_out = sum_q;

  always @(posedge clk) begin
    add_ack <= 1'b0;
    if (add_en && ack_delay != 0) begin
      sum_q <= 16'(add_a) + 16'(add_b);
      if (ack_delay == 1) add_ack <= 1'b1;
      else pend <= ack_delay - 1;
    end else if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) add_ack <= 1'b1;
    end
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_en = 1'b0;
  logic        spacing_on = 1'b0;
  logic        last_hs_ok = 1'b0;
  int          last_hs = 0;
  int          n_results = 0;
  logic [15:0] exp_ops;
  logic [16:0] exp_res;

  always @(negedge clk) begin
    if (add_en) begin
      chk("add_en_single_cycle", 32'(prev_en), 32'd0);
      if (issue_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_issue: got a=%0d b=%0d, expected no issue", add_a, add_b);
      end else begin
        exp_ops = issue_q.pop_front();
        chk("issue_operands", 32'({add_a, add_b}), 32'(exp_ops));
      end
    end
    prev_en = add_en;
    if (res_valid && res_ready) begin
      n_results++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_result: got data=%0d err=%0b, expected none", res_data, res_err);
      end else begin
        exp_res = exp_q.pop_front();
        chk("result", 32'({res_err, res_data}), 32'(exp_res));
      end
      if (spacing_on && last_hs_ok) chk("result_spacing", 32'(cyc - last_hs), 32'd3);
      last_hs    = cyc;
      last_hs_ok = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [16:0] exp);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL push_stall: in_ready=%0b, required 1 within 50 cycles", in_ready);
    end
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    issue_q.push_back({a, b});
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || res_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL %s: drain timeout, got %0d results pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    int          delay;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int base;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    res_ready = 1'b1;

    vecs[0] = '{8'd255, 8'd255, 1, 16'd510, 1'b0};
    vecs[1] = '{8'd0,   8'd0,   1, 16'd0,   1'b0};
    vecs[2] = '{8'd128, 8'd128, 2, 16'd256, 1'b0};
    vecs[3] = '{8'd100, 8'd27,  5, 16'd127, 1'b0};
    vecs[4] = '{8'd1,   8'd1,   8, 16'd2,   1'b0};
    vecs[5] = '{8'd2,   8'd2,   9, 16'd0,   1'b1};
    vecs[6] = '{8'd9,   8'd90,  0, 16'd0,   1'b1};
    vecs[7] = '{8'd200, 8'd55,  3, 16'd255, 1'b0};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_fifo_cnt",  32'(fifo_cnt),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_add_en",    32'(add_en),    32'd0);
    chk("rst_add_ab",    32'({add_a, add_b}), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_res_err",   32'(res_err),   32'd0);
    chk("rst_err_cnt",   32'(err_cnt),   32'd0);

    // --- single transaction, cycle by cycle ---
    push(8'd7, 8'd1, {1'b0, 16'd8});
    @(negedge clk);
    chk("t1_cnt_after_push", 32'(fifo_cnt), 32'd1);
    chk("t1_en_before_pop",  32'(add_en),   32'd0);
    @(negedge clk);
    chk("t1_en_issue",  32'(add_en),   32'd1);
    chk("t1_add_a",     32'(add_a),    32'd7);
    chk("t1_add_b",     32'(add_b),    32'd1);
    chk("t1_cnt_pop",   32'(fifo_cnt), 32'd0);
    @(negedge clk);
    chk("t1_en_drop",   32'(add_en),    32'd0);
    chk("t1_rv_early",  32'(res_valid), 32'd0);
    @(negedge clk);
    chk("t1_rv",        32'(res_valid), 32'd1);
    chk("t1_data",      32'(res_data),  32'd8);
    chk("t1_err",       32'(res_err),   32'd0);
    @(negedge clk);
    chk("t1_rv_one_cycle", 32'(res_valid), 32'd0);
    chk("t1_err_cnt",      32'(err_cnt),   32'd0);
    chk("t1_add_a_held",   32'(add_a),     32'd7);

    // --- timeout on a dead adder, then recovery ---
    ack_delay = 0;
    push(8'd14, 8'd11, {1'b1, 16'd0});
    err_model++;
    n = 0;
    while (!add_en && n < 20) begin @(negedge clk); n++; end
    chk("t4_issue_seen", 32'(add_en), 32'd1);
    n = 0;
    while (!res_valid && n < 30) begin @(negedge clk); n++; end
    chk("t4_timeout_latency", 32'(n), 32'd9);
    chk("t4_err_flag", 32'(res_err), 32'd1);
    chk("t4_data_zero", 32'(res_data), 32'd0);
    wait_drain("t4_drain");
    chk("t4_err_cnt", 32'(err_cnt), 32'(err_model));
    ack_delay = 1;
    push(8'd24, 8'd45, {1'b0, 16'd69});
    wait_drain("t4_recover");

    // --- ack on final WAIT cycle, then an ack 2 cycles late ---
    ack_delay = 8;
    push(8'd3, 8'd4, {1'b0, 16'd7});
    wait_drain("t5_last_cycle_ack");
    chk("t5_err_cnt_same", 32'(err_cnt), 32'(err_model));
    ack_delay = 10;
    push(8'd9, 8'd9, {1'b1, 16'd0});
    err_model++;
    wait_drain("t5_late_ack");
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (res_valid) n++;
    end
    chk("t5_no_spurious_valid", 32'(n), 32'd0);
    chk("t5_err_cnt", 32'(err_cnt), 32'(err_model));

    // --- directed vector table ---
    for (int i = 0; i < 8; i++) begin
      ack_delay = vecs[i].delay;
      push(vecs[i].a, vecs[i].b, {vecs[i].exp_err, vecs[i].exp_data});
      if (vecs[i].exp_err) err_model++;
      wait_drain("vec_drain");
      chk("vec_err_cnt", 32'(err_cnt), 32'(err_model));
    end
    ack_delay = 1;

    // --- back-to-back pushes with a stalled consumer ---
    res_ready = 1'b0;
    push(8'd6,  8'd8,  {1'b0, 16'd14});
    push(8'd7,  8'd0,  {1'b0, 16'd7});
    push(8'd5,  8'd6,  {1'b0, 16'd11});
    push(8'd71, 8'd23, {1'b0, 16'd94});
    @(negedge clk);
    chk("t2_fifo_cnt", 32'(fifo_cnt), 32'd3);
    chk("t2_in_ready", 32'(in_ready), 32'd1);
    n = 0;
    while (!res_valid && n < 20) begin @(negedge clk); n++; end
    chk("t2_first_held", 32'(res_valid), 32'd1);
    spacing_on = 1'b1;
    last_hs_ok = 1'b0;
    res_ready  = 1'b1;
    wait_drain("t2_drain");
    spacing_on = 1'b0;

    // --- fill the FIFO, refuse a 6th push, drain in order ---
    res_ready = 1'b0;
    base = n_results;
    push(8'd10, 8'd1, {1'b0, 16'd11});
    push(8'd20, 8'd2, {1'b0, 16'd22});
    push(8'd30, 8'd3, {1'b0, 16'd33});
    push(8'd40, 8'd4, {1'b0, 16'd44});
    push(8'd50, 8'd5, {1'b0, 16'd55});
    @(negedge clk);
    chk("t3_full_cnt",   32'(fifo_cnt), 32'd4);
    chk("t3_full_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_a     = 8'd99;
    in_b     = 8'd99;
    repeat (3) @(negedge clk);
    chk("t3_refused_cnt", 32'(fifo_cnt), 32'd4);
    in_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain("t3_drain");
    chk("t3_result_count", 32'(n_results - base), 32'd5);
    chk("t3_empty", 32'(fifo_cnt), 32'd0);

    // --- asynchronous reset while waiting with two entries queued ---
    ack_delay = 0;
    res_ready = 1'b0;
    push(8'd1, 8'd1, {1'b1, 16'd0});
    push(8'd2, 8'd2, {1'b1, 16'd0});
    push(8'd3, 8'd3, {1'b1, 16'd0});
    @(negedge clk);
    chk("t6_queued", 32'(fifo_cnt), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_cnt",   32'(fifo_cnt),  32'd0);
    chk("t6_rst_ready", 32'(in_ready),  32'd1);
    chk("t6_rst_en",    32'(add_en),    32'd0);
    chk("t6_rst_ab",    32'({add_a, add_b}), 32'd0);
    chk("t6_rst_rv",    32'(res_valid), 32'd0);
    chk("t6_rst_err",   32'(res_err),   32'd0);
    chk("t6_rst_ecnt",  32'(err_cnt),   32'd0);
    exp_q.delete();
    issue_q.delete();
    err_model = 0;
    ack_delay = 1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (add_en || fifo_cnt != 3'd0) n++;
    end
    chk("t6_no_issue_after_reset", 32'(n), 32'd0);
    res_ready = 1'b1;
    push(8'd1, 8'd2, {1'b0, 16'd3});
    wait_drain("t6_after_reset");
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);

    idle_cycles(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
